// File: rtl/sic_detector_pkg.sv
// Shared definitions for the SIC back-substitution detector.
// Build option: define SIC_PAM4_EN for the 4-PAM slicer (2-bit symbols);
// leave it undefined for the BPSK slicer (1-bit symbols).
package sic_detector_pkg;

  // Global datapath word length for R and z entries.
  localparam int WL = 16;

`ifdef SIC_PAM4_EN
  localparam int SW = 2;
`else
  localparam int SW = 1;
`endif

  // 4-PAM symbol codes (ordered so that the code increases with amplitude).
  localparam logic [1:0] CODE_P3 = 2'b11;
  localparam logic [1:0] CODE_P1 = 2'b10;
  localparam logic [1:0] CODE_M1 = 2'b01;
  localparam logic [1:0] CODE_M3 = 2'b00;

  // BPSK symbol codes.
  localparam logic CODE_BP = 1'b1;
  localparam logic CODE_BM = 1'b0;

  // Signed symbol amplitudes fed back into the residual.
  localparam logic signed [2:0] SYM_P3 = 3'sd3;
  localparam logic signed [2:0] SYM_P1 = 3'sd1;
  localparam logic signed [2:0] SYM_M1 = -3'sd1;
  localparam logic signed [2:0] SYM_M3 = -3'sd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Residual accumulator width: z plus up to N-1 products of |s| <= 3
  // can never exceed this, so no saturation logic is needed.
  function automatic int acc_width(input int n);
    return WL + 3 + $clog2(n);
  endfunction

endpackage

// File: rtl/sic_detector_if.sv
// R/z input bundle and decision output handshake of the SIC detector.
// Symbol width follows SIC_PAM4_EN through the package.
interface sic_detector_if
  import sic_detector_pkg::*;
#(
  parameter int N = 8
);
  logic [WL*N*N-1:0] Hmatrix_i;
  logic [WL*N-1:0]   Yarray_i;
  logic              in_valid;
  logic              in_ready;
  logic [SW*N-1:0]   xhat_o;
  logic              out_valid;
  logic              out_ready;

  // Detector side.
  modport slave (
    input  Hmatrix_i, Yarray_i, in_valid, out_ready,
    output in_ready, xhat_o, out_valid
  );

  // QR stage / demapper side.
  modport master (
    output Hmatrix_i, Yarray_i, in_valid, out_ready,
    input  in_ready, xhat_o, out_valid
  );
endinterface

// File: rtl/sic_row_slicer.sv
// Combinational hard-decision slicer for one row of the back-substitution.
// SIC_PAM4_EN selects 4-PAM (threshold 2*r_ii) instead of BPSK.
module sic_row_slicer
  import sic_detector_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic signed [WL-1:0] r_ii_i,
  input  logic signed [AW-1:0] e_i,
  output logic [SW-1:0]        code_o,
  output logic signed [2:0]    sym_o
);

  logic degen;
  logic e_nonneg;

  // A non-positive diagonal gives no usable scale, so only the sign is trusted.
  assign degen    = r_ii_i[WL-1] || (r_ii_i == '0);
  assign e_nonneg = ~e_i[AW-1];

`ifdef SIC_PAM4_EN
  logic signed [AW-1:0] thr;
  assign thr = AW'(r_ii_i) <<< 1;

  // Four-level decision; ties go to the upper level.
  always_comb begin
    code_o = CODE_M3;
    sym_o  = SYM_M3;
    if (degen) begin
      code_o = e_nonneg ? CODE_P1 : CODE_M1;
      sym_o  = e_nonneg ? SYM_P1 : SYM_M1;
    end else if (e_i >= thr) begin
      code_o = CODE_P3;
      sym_o  = SYM_P3;
    end else if (e_nonneg) begin
      code_o = CODE_P1;
      sym_o  = SYM_P1;
    end else if (e_i >= -thr) begin
      code_o = CODE_M1;
      sym_o  = SYM_M1;
    end
  end
`else
  // Sign decision; the degenerate fallback coincides with normal BPSK.
  always_comb begin
    code_o = CODE_BM;
    sym_o  = SYM_M1;
    if (degen) begin
      code_o = e_nonneg ? CODE_BP : CODE_BM;
      sym_o  = e_nonneg ? SYM_P1 : SYM_M1;
    end else if (e_nonneg) begin
      code_o = CODE_BP;
      sym_o  = SYM_P1;
    end
  end
`endif

endmodule

// File: rtl/sic_detector.sv
// SIC back-substitution detector: captures R and z, resolves one row per
// clock from N-1 down to 0 feeding earlier decisions back, then holds the
// decision vector until the demapper takes it.
// Build option: SIC_PAM4_EN (4-PAM slicer); BPSK when undefined.
module sic_detector
  import sic_detector_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  sic_detector_if.slave  bus
);

  localparam int AW = acc_width(N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 out_valid_q, out_valid_d;
  logic [SW*N-1:0]      xhat_q;
  logic signed [2:0]    sym_q [N];
  logic signed [WL-1:0] r_q [N][N];
  logic signed [WL-1:0] z_q [N];

  logic signed [AW-1:0] term [N];
  logic signed [AW-1:0] acc;
  logic [SW-1:0]        slice_code;
  logic signed [2:0]    slice_sym;

  // Feedback products for the current row; only columns right of the
  // diagonal contribute, the lower triangle is never looked at.  With BPSK
  // the symbol operand is +/-1, so each product is just a conditional negate.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      logic signed [AW-1:0] r_ext;
      logic signed [AW-1:0] s_ext;
      assign r_ext    = AW'(r_q[row_q][gi]);
      assign s_ext    = AW'(sym_q[gi]);
      assign term[gi] = (RW'(gi) > row_q) ? r_ext * s_ext : '0;
    end
  endgenerate

  // Residual e_i = z_i - sum_{j>i} r_ij * s_j.
  always_comb begin
    acc = AW'(z_q[row_q]);
    for (int j = 0; j < N; j++) begin
      acc = acc - term[j];
    end
  end

  sic_row_slicer #(
    .AW (AW)
  ) u_slicer (
    .r_ii_i (r_q[row_q][row_q]),
    .e_i    (acc),
    .code_o (slice_code),
    .sym_o  (slice_sym)
  );

  // Next-state, row counter and output-valid decode.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_SOLVE;
          row_d   = RW'(N - 1);
        end
      end
      ST_SOLVE: begin
        row_d = row_q - RW'(1);
        if (row_q == '0) begin
          state_d     = ST_DONE;
          row_d       = '0;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and output-valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bundle capture on acceptance and one decision written per solve cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xhat_q <= '0;
      for (int i = 0; i < N; i++) begin
        sym_q[i] <= '0;
        z_q[i]   <= '0;
        for (int j = 0; j < N; j++) begin
          r_q[i][j] <= '0;
        end
      end
    end else if ((state_q == ST_IDLE) && bus.in_valid) begin
      xhat_q <= '0;
      for (int i = 0; i < N; i++) begin
        sym_q[i] <= '0;
        z_q[i]   <= bus.Yarray_i[i*WL +: WL];
        for (int j = 0; j < N; j++) begin
          r_q[i][j] <= bus.Hmatrix_i[(i*N + j)*WL +: WL];
        end
      end
    end else if (state_q == ST_SOLVE) begin
      xhat_q[int'(row_q)*SW +: SW] <= slice_code;
      sym_q[row_q]                 <= slice_sym;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.xhat_o    = xhat_q;

endmodule

// File: tb/tb_sic_detector.sv
// Scoreboard bench for sic_detector (N=8), valid for both SIC_PAM4_EN builds.
module tb_sic_detector;
  import sic_detector_pkg::*;

  localparam int N  = 8;
  localparam int XW = SW * N;

`ifdef SIC_PAM4_EN
  localparam logic [XW-1:0] T1_EXP  = 16'h2E1B;
  localparam logic [XW-1:0] T5_EXP  = 16'h9A66;
  localparam logic [XW-1:0] T6A_EXP = 16'hAAAA;
  localparam logic [XW-1:0] T6B_EXP = 16'hAA6A;
`else
  localparam logic [XW-1:0] T1_EXP  = 8'h73;
  localparam logic [XW-1:0] T5_EXP  = 8'hB5;
  localparam logic [XW-1:0] T6A_EXP = 8'hFF;
  localparam logic [XW-1:0] T6B_EXP = 8'hF7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  sic_detector_if #(.N(N)) bus ();

  sic_detector #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int R [N][N];
  int Z [N];
  logic [XW-1:0] sb_q [$];
  logic [XW-1:0] got;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural back-substitution reference.
  function automatic logic [XW-1:0] model_xhat();
    int s [N];
    int e;
    int t;
    logic [XW-1:0] x;
    x = '0;
    for (int i = N - 1; i >= 0; i--) begin
      e = Z[i];
      for (int j = i + 1; j < N; j++) e -= R[i][j] * s[j];
`ifdef SIC_PAM4_EN
      t = 2 * R[i][i];
      if (R[i][i] <= 0) begin
        s[i] = (e >= 0) ? 1 : -1;
        x[2*i +: 2] = (e >= 0) ? 2'b10 : 2'b01;
      end else if (e >= t) begin
        s[i] = 3;  x[2*i +: 2] = 2'b11;
      end else if (e >= 0) begin
        s[i] = 1;  x[2*i +: 2] = 2'b10;
      end else if (e >= -t) begin
        s[i] = -1; x[2*i +: 2] = 2'b01;
      end else begin
        s[i] = -3; x[2*i +: 2] = 2'b00;
      end
`else
      t = 0;
      s[i] = (e >= 0) ? 1 : -1;
      x[i] = (e >= t);
`endif
    end
    return x;
  endfunction

  task automatic set_diag(input int d, input int zv);
    for (int i = 0; i < N; i++) begin
      Z[i] = zv;
      for (int j = 0; j < N; j++) R[i][j] = (i == j) ? d : 0;
    end
  endtask

  task automatic add_junk();
    for (int i = 1; i < N; i++)
      for (int j = 0; j < i; j++) R[i][j] = int'($urandom_range(1, 40)) - 50;
  endtask

  task automatic load_bus();
    for (int i = 0; i < N; i++) begin
      bus.Yarray_i[i*WL +: WL] = WL'(Z[i]);
      for (int j = 0; j < N; j++) bus.Hmatrix_i[(i*N + j)*WL +: WL] = WL'(R[i][j]);
    end
  endtask

  // Present the bundle for one accepted cycle and log its expected result.
  task automatic accept_bundle();
    int w = 0;
    load_bus();
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check_eq("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(model_xhat());
  endtask

  // Wait for the vector, compare, optionally stall, then hand it off.
  task automatic collect(input string tag, input int hold, output logic [XW-1:0] obs);
    int cyc = 0;
    logic [XW-1:0] exp;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(N));
    obs = bus.xhat_o;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    check_eq({tag, "_xhat"}, 64'(obs), 64'(exp));
    $display("txn %s xhat=%0h expected=%0h latency=%0d", tag, obs, exp, cyc);
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        Z[0] = Z[0] + 77;
        Z[7] = -Z[7];
        load_bus();
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check_eq({tag, "_hold_xhat"}, 64'(bus.xhat_o), 64'(exp));
      check_eq({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      check_eq({tag, "_hold_out_valid"}, 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_eq({tag, "_post_out_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic load_test1();
    set_diag(4, 0);
    Z[0] = 12; Z[1] = 4; Z[2] = -4; Z[3] = -12;
    Z[4] = 0;  Z[5] = 8; Z[6] = 7;  Z[7] = -9;
  endtask

  initial begin
    int t_first;
    int t_second;
    logic [XW-1:0] exp;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Hmatrix_i = '0;
    bus.Yarray_i  = '0;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_xhat", 64'(bus.xhat_o), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Diagonal slicing.
    load_test1();
    accept_bundle();
    collect("diag", 0, got);
    check_eq("diag_codes", 64'(got), 64'(T1_EXP));

    // Feedback with lower-triangle junk.
    set_diag(4, 4);
    Z[7] = 12; Z[6] = 6; R[6][7] = 2;
    add_junk();
    accept_bundle();
    collect("feedback", 0, got);

    // Backpressure with an ignored in_valid pulse.
    load_test1();
    R[2][5] = 3; R[0][7] = -2;
    accept_bundle();
    collect("backpressure", 5, got);

    // Reset three cycles after acceptance.
    load_test1();
    accept_bundle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_xhat", 64'(bus.xhat_o), 64'd0);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1;
    check_eq("midrst_no_output", 64'(bus.out_valid), 64'd0);
    set_diag(4, 4);
    Z[7] = 12; Z[6] = 6; R[6][7] = 2;
    accept_bundle();
    collect("after_reset", 0, got);

    // BPSK reference vector.
    set_diag(4, 0);
    Z[0] = 3; Z[1] = -1; Z[2] = 0; Z[3] = -5;
    Z[4] = 1; Z[5] = 1;  Z[6] = -1; Z[7] = 2;
    accept_bundle();
    collect("bpsk_vec", 0, got);
    check_eq("bpsk_vec_codes", 64'(got), 64'(T5_EXP));

    // Degenerate diagonal.
    set_diag(4, 4);
    R[3][3] = 0; Z[3] = 20;
    accept_bundle();
    collect("degen_zero", 0, got);
    check_eq("degen_zero_codes", 64'(got), 64'(T6A_EXP));
    set_diag(4, 4);
    R[3][3] = -4; Z[3] = -20;
    accept_bundle();
    collect("degen_neg", 0, got);
    check_eq("degen_neg_codes", 64'(got), 64'(T6B_EXP));

    // Random upper-triangular systems.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) begin
        Z[i] = int'($urandom_range(0, 200)) - 100;
        R[i][i] = int'($urandom_range(0, 22)) - 2;
        for (int j = i + 1; j < N; j++) R[i][j] = int'($urandom_range(0, 16)) - 8;
      end
      add_junk();
      accept_bundle();
      collect($sformatf("random%0d", v), 0, got);
    end

    // Throughput with out_ready tied high and in_valid held.
    set_diag(4, 4);
    Z[7] = 12; Z[6] = 6; R[6][7] = 2;
    load_bus();
    exp = model_xhat();
    sb_q.push_back(exp);
    sb_q.push_back(exp);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    t_first  = -1;
    t_second = -1;
    for (int c = 0; c < 40 && t_second < 0; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        if (t_first < 0) t_first = c;
        else t_second = c;
        if (t_second >= 0) bus.in_valid = 1'b0;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
        check_eq("tput_xhat", 64'(bus.xhat_o), 64'(exp));
        $display("txn tput cycle=%0d xhat=%0h expected=%0h", c, bus.xhat_o, exp);
      end
    end
    bus.in_valid = 1'b0;
    check_eq("tput_gap", 64'(t_second - t_first), 64'(N + 2));
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check_eq("tput_idle", 64'(bus.in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sic_detector.md
# sic_detector

Successive-interference-cancellation (SIC) back-substitution detector. It consumes the upper-triangular R matrix and rotated receive vector z = Qᴴy produced by the Givens-rotation QR stage, and emits hard symbol decisions. Rows are resolved bottom-up, one row per clock, with earlier decisions fed back. It is the consumer end of the QR stage's flattened H/Y bus, and sits between QR preprocessing and the symbol demapper in the real-valued MIMO detector.

## Interface
- `N`, default 8: real-valued system dimension (matrix is N×N); minimum 2.
- `WL`: global word length from `parameters.v`; not a module parameter.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous and active-low.
- `Hmatrix_i`, in, `WL*N*N`: R matrix, signed.
  - Row i occupies `[(i+1)*WL*N-1 : i*WL*N]`.
  - Column j within a row occupies word j.
- `Yarray_i`, in, `WL*N`: z vector, signed; element i occupies `[(i+1)*WL-1 : i*WL]`.
- `in_valid`, in, 1: the R/z bundle is valid.
- `in_ready`, out, 1: the block accepts a bundle.
- `xhat_o`, out, `SW*N`: decisions; symbol i occupies `[(i+1)*SW-1 : i*SW]`. SW is 2 with `SIC_PAM4_EN` and 1 without it.
- `out_valid`, out, 1: `xhat_o` holds a complete vector.
- `out_ready`, in, 1: downstream accepts `xhat_o`.

## Operation
- **States.** IDLE, SOLVE, DONE.
  - IDLE: `in_ready`=1. When `in_valid`=1, capture all R and z words into internal registers, set the row counter to N-1, and clear the decision registers. Go to SOLVE.
  - SOLVE: each cycle, resolve row `i` = counter. Decrement the counter. After row 0, go to DONE.
  - DONE: `out_valid`=1 and `xhat_o` is held stable. When `out_ready`=1, go to IDLE.
- **Backpressure.** `in_ready` is 0 in SOLVE and DONE. `in_valid` is ignored outside IDLE. Input buses may change after capture.
- **Residual.** e_i = z_i − Σ_{j>i} r_ij·s_j.
  - s_j is the signed value of the decision already made for row j.
  - Entries with j<i (lower triangle) are never read. They are not assumed to be zero.
  - Products are exact, and the accumulator is `WL+3+$clog2(N)` bits signed. There is no saturation and no overflow is possible.
- **PAM-4 slicing (macro defined).** The threshold is T = 2·r_ii.
  - e ≥ T → +3, code 2'b11.
  - 0 ≤ e < T → +1, code 2'b10.
  - −T ≤ e < 0 → −1, code 2'b01.
  - e < −T → −3, code 2'b00.
  - Ties resolve upward as written.
- **BPSK slicing (macro absent).** e ≥ 0 → +1, code 1'b1. Otherwise −1, code 1'b0.
- **Degenerate diagonal.** If r_ii ≤ 0, the decision falls back to sign only: e ≥ 0 gives +1, otherwise −1. This applies in both modes.
- **Reset values.** `out_valid`=0 and `xhat_o`=0. State is IDLE, so `in_ready`=1. All captured registers and the counter are 0.
- **Reset mid-operation.** Reset in SOLVE or DONE discards the vector immediately. No partial output is ever presented.

## Timing
- **Acceptance.** A bundle is accepted at rising edge k, when `in_valid` & `in_ready`.
- **Row resolution.** Row N-1 is decided at edge k+1 and row i at edge k+N−i. `out_valid` rises after edge k+N.
- **Latency.** N cycles from acceptance to `out_valid`, with no dependence on data.
- **Output handshake.** Occurs at the first edge where `out_valid` & `out_ready`. `in_ready` is high from the following cycle.
- **Throughput.** With `out_ready` tied high, one vector is processed every N+2 cycles.
- **Registered outputs.** `out_valid` and `xhat_o` are registered. `in_ready` is decoded from the state register only.

## Configuration
- **`SIC_PAM4_EN` defined:** 4-PAM slicer, SW=2, threshold datapath (2·r_ii compare) present.
- **`SIC_PAM4_EN` absent:** BPSK slicer, SW=1.
  - The feedback multiply reduces to conditional negate.
  - The threshold compare is removed.

## Structure
- **Shared package / `parameters.v` additions:**
  - SW.
  - Symbol code constants.
  - The state encoding (IDLE, SOLVE, DONE).
  - The accumulator-width expression.
- **Sub-module `sic_row_slicer`:** combinational. It takes r_ii, e_i and the mode, and returns the code and signed symbol value.
- **Top level:** the residual MAC tree, counter, FSM and registers.

## Test plan
All cases use N=8 and the PAM-4 build unless stated otherwise.
1. **Diagonal slicing.** R=4·I, z=[12,4,−4,−12,0,8,7,−9] → codes [11,10,01,00,10,11,10,00]. `out_valid` rises exactly 8 cycles after acceptance.
2. **Feedback.**
   - Input: r77=4, z7=12, r66=4, r67=2, z6=6, other rows R=4·I, z=4.
   - Row 7: s7=+3 (code 11).
   - Row 6: e6=6−6=0 → +1 (code 10).
   - Non-zero junk in the lower triangle must not change any result.
3. **Backpressure.**
   - Hold `out_ready`=0 for 5 cycles after `out_valid`: `xhat_o` stays stable, `in_ready`=0, and a pulse on `in_valid` is ignored.
   - Raise `out_ready`: `in_ready` goes high the next cycle.
4. **Reset mid-solve.** Assert `rst` low 3 cycles after acceptance → `out_valid`=0, `xhat_o`=0 and `in_ready`=1 immediately. A new vector afterwards completes correctly.
5. **BPSK build (macro absent).** R=4·I, z=[3,−1,0,−5,1,1,−1,2] → bits [1,0,1,0,1,1,0,1].
6. **Degenerate diagonal.** r33=0 with e3=20 → +1 (code 10), not +3. r33=−4 with e3=−20 → −1 (code 01).
